// File: rtl/axis_fb_writer.sv
// -----------------------------------------------------------------------------
// axis_fb_writer
//
// Framebuffer write stage. Each pixel beat accepted from an AXI-Stream source
// becomes one addressed memory write. The block tracks the (x, y) position
// against the configured resolution. It aligns to start-of-frame (tuser[0])
// and end-of-line (tlast), and clamps every write inside the framebuffer
// window.
//
// Optional feature macro: AXIS_FB_WRITER_ERR_CNT_EN
//   When defined, adds a 16-bit saturating error counter output err_count.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axis_tdata/tvalid   pixel stream input (tlast = end of line,
//   s_axis_tready/tlast   tuser = start of frame)
//   s_axis_tuser
//   m_wr_addr/data        write request (held stable until m_wr_ready)
//   m_wr_valid/ready
//   frame_done            one-cycle pulse after the last pixel of a frame
//   err_short_line        one-cycle pulse: tlast before the end of the line
//   err_long_line         one-cycle pulse: first beat beyond H_RES in a line
//   err_sof               one-cycle pulse: SOF in the middle of a frame
//   busy                  high while inside a frame
//   err_count             (macro only) saturating count of error pulses
// -----------------------------------------------------------------------------
module axis_fb_writer #(
   parameter int                    DATA_WIDTH   = 24,
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    H_RES        = 640,
   parameter int                    V_RES        = 480,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int                    PIXEL_STRIDE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic [ADDR_WIDTH-1:0] m_wr_addr,
   output logic [DATA_WIDTH-1:0] m_wr_data,
   output logic                  m_wr_valid,
   input  logic                  m_wr_ready,
   output logic                  frame_done,
   output logic                  err_short_line,
   output logic                  err_long_line,
   output logic                  err_sof,
   output logic                  busy
`ifdef AXIS_FB_WRITER_ERR_CNT_EN
   ,
   output logic [15:0]           err_count
`endif
);

   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam logic [XW-1:0]         X_LAST     = XW'(H_RES - 1);
   localparam logic [YW-1:0]         Y_LAST     = YW'(V_RES - 1);
   localparam logic [ADDR_WIDTH-1:0] STRIDE_A   = ADDR_WIDTH'(PIXEL_STRIDE);
   localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(H_RES * PIXEL_STRIDE);
   localparam logic [ADDR_WIDTH-1:0] LINE1_ADDR = BASE_ADDR + LINE_BYTES;

   typedef enum logic [1:0] {
      ST_WAIT_SOF = 2'd0,
      ST_ACTIVE   = 2'd1,
      ST_DROP     = 2'd2
   } state_t;

   state_t                  state_q;
   logic [XW-1:0]           x_q;
   logic [YW-1:0]           y_q;
   logic [ADDR_WIDTH-1:0]   line_base_q;
   logic [ADDR_WIDTH-1:0]   pix_addr_q;
   logic                    long_seen_q;
   logic                    m_wr_valid_q;
   logic [ADDR_WIDTH-1:0]   m_wr_addr_q;
   logic [DATA_WIDTH-1:0]   m_wr_data_q;
   logic                    frame_done_q;
   logic                    err_short_q;
   logic                    err_long_q;
   logic                    err_sof_q;
   logic                    busy_q;

   logic                    accept_s;
   logic                    x_last_s;
   logic                    y_last_s;
   logic [ADDR_WIDTH-1:0]   next_line_s;

   // A new beat is taken whenever the output register is free or draining.
   assign s_axis_tready = rst_n & (~m_wr_valid_q | m_wr_ready);
   assign accept_s      = s_axis_tvalid & s_axis_tready;
   assign x_last_s      = (x_q == X_LAST);
   assign y_last_s      = (y_q == Y_LAST);
   assign next_line_s   = line_base_q + LINE_BYTES;

   // Position tracking FSM, write request register and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_WAIT_SOF;
         x_q          <= '0;
         y_q          <= '0;
         line_base_q  <= BASE_ADDR;
         pix_addr_q   <= BASE_ADDR;
         long_seen_q  <= 1'b0;
         m_wr_valid_q <= 1'b0;
         m_wr_addr_q  <= '0;
         m_wr_data_q  <= '0;
         frame_done_q <= 1'b0;
         err_short_q  <= 1'b0;
         err_long_q   <= 1'b0;
         err_sof_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         err_short_q  <= 1'b0;
         err_long_q   <= 1'b0;
         err_sof_q    <= 1'b0;
         if (m_wr_ready) begin
            m_wr_valid_q <= 1'b0;
         end
         if (accept_s) begin
            if (s_axis_tuser) begin
               // SOF always restarts at pixel (0,0), whatever the state.
               m_wr_valid_q <= 1'b1;
               m_wr_addr_q  <= BASE_ADDR;
               m_wr_data_q  <= s_axis_tdata;
               err_sof_q    <= (state_q != ST_WAIT_SOF);
               long_seen_q  <= 1'b0;
               if (s_axis_tlast) begin
                  // One-pixel line: short line, then end of line 0.
                  err_short_q <= 1'b1;
                  if (V_RES == 1) begin
                     frame_done_q <= 1'b1;
                     state_q      <= ST_WAIT_SOF;
                     busy_q       <= 1'b0;
                  end else begin
                     x_q         <= '0;
                     y_q         <= YW'(1);
                     line_base_q <= LINE1_ADDR;
                     pix_addr_q  <= LINE1_ADDR;
                     state_q     <= ST_ACTIVE;
                     busy_q      <= 1'b1;
                  end
               end else begin
                  x_q         <= XW'(1);
                  y_q         <= '0;
                  line_base_q <= BASE_ADDR;
                  pix_addr_q  <= BASE_ADDR + STRIDE_A;
                  state_q     <= ST_ACTIVE;
                  busy_q      <= 1'b1;
               end
            end else begin
               case (state_q)
                  ST_ACTIVE: begin
                     m_wr_valid_q <= 1'b1;
                     m_wr_addr_q  <= pix_addr_q;
                     m_wr_data_q  <= s_axis_tdata;
                     if (s_axis_tlast) begin
                        err_short_q <= ~x_last_s;
                     end else if (x_last_s) begin
                        // Line is full; anything further is dropped.
                        state_q     <= ST_DROP;
                        long_seen_q <= 1'b0;
                     end else begin
                        x_q        <= x_q + XW'(1);
                        pix_addr_q <= pix_addr_q + STRIDE_A;
                     end
                  end
                  ST_DROP: begin
                     err_long_q  <= ~long_seen_q;
                     long_seen_q <= 1'b1;
                  end
                  ST_WAIT_SOF: begin
                     state_q <= ST_WAIT_SOF;
                  end
                  default: begin
                     state_q <= ST_WAIT_SOF;
                     busy_q  <= 1'b0;
                  end
               endcase
               // End of line, shared by ACTIVE and DROP; overrides the above.
               if (s_axis_tlast && (state_q != ST_WAIT_SOF)) begin
                  if (y_last_s) begin
                     frame_done_q <= 1'b1;
                     state_q      <= ST_WAIT_SOF;
                     busy_q       <= 1'b0;
                  end else begin
                     x_q         <= '0;
                     y_q         <= y_q + YW'(1);
                     line_base_q <= next_line_s;
                     pix_addr_q  <= next_line_s;
                     state_q     <= ST_ACTIVE;
                     busy_q      <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign m_wr_valid     = m_wr_valid_q;
   assign m_wr_addr      = m_wr_addr_q;
   assign m_wr_data      = m_wr_data_q;
   assign frame_done     = frame_done_q;
   assign err_short_line = err_short_q;
   assign err_long_line  = err_long_q;
   assign err_sof        = err_sof_q;
   assign busy           = busy_q;

`ifdef AXIS_FB_WRITER_ERR_CNT_EN
   logic [15:0] err_count_q;
   logic [17:0] err_sum_s;

   // Short and SOF can pulse together (SOF beat carrying tlast), so add them all.
   assign err_sum_s = {2'b00, err_count_q} + {17'd0, err_short_q}
                    + {17'd0, err_long_q} + {17'd0, err_sof_q};

   // Saturating error counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count_q <= 16'h0000;
      end else if (err_sum_s > 18'h0FFFF) begin
         err_count_q <= 16'hFFFF;
      end else begin
         err_count_q <= err_sum_s[15:0];
      end
   end

   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_axis_fb_writer.sv
// -----------------------------------------------------------------------------
// Testbench for axis_fb_writer (H_RES=4, V_RES=2, BASE_ADDR=0x100, stride 4).
// A reference model runs on falling edges: it sees every accepted beat and
// pushes expected writes and status pulses into queues. A monitor runs 2 time
// units after each rising edge: it pops those queues and compares them with
// the DUT outputs.
// -----------------------------------------------------------------------------
module tb_axis_fb_writer;

   localparam int          H      = 4;
   localparam int          V      = 2;
   localparam logic [31:0] BASE   = 32'h0000_0100;
   localparam int          STRIDE = 4;

   typedef struct packed {
      logic fd;
      logic shrt;
      logic lng;
      logic sof;
      logic busy;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        s_axis_tlast;
   logic        s_axis_tuser;
   logic [31:0] m_wr_addr;
   logic [23:0] m_wr_data;
   logic        m_wr_valid;
   logic        m_wr_ready;
   logic        frame_done;
   logic        err_short_line;
   logic        err_long_line;
   logic        err_sof;
   logic        busy;
`ifdef AXIS_FB_WRITER_ERR_CNT_EN
   logic [15:0] err_count;
`endif

   axis_fb_writer #(
      .DATA_WIDTH  (24),
      .ADDR_WIDTH  (32),
      .H_RES       (H),
      .V_RES       (V),
      .BASE_ADDR   (BASE),
      .PIXEL_STRIDE(STRIDE)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_wr_addr     (m_wr_addr),
      .m_wr_data     (m_wr_data),
      .m_wr_valid    (m_wr_valid),
      .m_wr_ready    (m_wr_ready),
      .frame_done    (frame_done),
      .err_short_line(err_short_line),
      .err_long_line (err_long_line),
      .err_sof       (err_sof),
      .busy          (busy)
`ifdef AXIS_FB_WRITER_ERR_CNT_EN
      ,
      .err_count     (err_count)
`endif
   );

   always #5 clk = ~clk;

   int          n_vec  = 0;
   int          n_fail = 0;
   int          n_wr   = 0;
   int          n_fd   = 0;
   int          n_short = 0;
   int          n_long = 0;
   int          n_sof  = 0;
   logic [55:0] wq[$];
   exp_t        fq[$];
   logic [31:0] obs_addr[$];
   bit          rand_rdy = 1'b0;
   bit          gap_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: pixel index k within line ln; address = BASE + (ln*H+k)*STRIDE
   bit in_frame = 1'b0;
   int ln = 0;
   int k  = 0;
   initial forever begin
      exp_t e;
      @(negedge clk);
      e = '0;
      if (!rst_n) begin
         in_frame = 1'b0;
      end else if (s_axis_tvalid && s_axis_tready) begin
         if (s_axis_tuser) begin
            e.sof    = in_frame;
            in_frame = 1'b1;
            ln       = 0;
            k        = 0;
         end
         if (in_frame) begin
            if (k < H)
               wq.push_back({BASE + 32'((ln * H + k) * STRIDE), s_axis_tdata});
            if (k == H)
               e.lng = 1'b1;
            if (s_axis_tlast) begin
               if (k < H - 1)
                  e.shrt = 1'b1;
               ln++;
               k = 0;
               if (ln == V) begin
                  e.fd     = 1'b1;
                  in_frame = 1'b0;
               end
            end else begin
               k++;
            end
         end
      end
      e.busy = in_frame;
      fq.push_back(e);
   end

   // Monitor: compares DUT outputs with the queued expectations
   bit          stalled = 1'b0;
   logic [31:0] st_addr;
   logic [23:0] st_data;
   int          mon_cnt = 0;
   initial forever begin
      exp_t e;
      bit   have;
      logic [55:0] w;
      @(posedge clk);
      #2;
      have = (fq.size() > 0);
      e    = have ? fq.pop_front() : exp_t'('0);
      chk("tready_rule", s_axis_tready, rst_n && (!m_wr_valid || m_wr_ready));
      chk("frame_done", frame_done, e.fd);
      chk("err_short_line", err_short_line, e.shrt);
      chk("err_long_line", err_long_line, e.lng);
      chk("err_sof", err_sof, e.sof);
      if (have) chk("busy", busy, e.busy);
      n_fd    += int'(frame_done);
      n_short += int'(err_short_line);
      n_long  += int'(err_long_line);
      n_sof   += int'(err_sof);
`ifdef AXIS_FB_WRITER_ERR_CNT_EN
      if (!rst_n) mon_cnt = 0;
      chk("err_count", err_count, mon_cnt);
      mon_cnt += int'(err_short_line) + int'(err_long_line) + int'(err_sof);
      if (mon_cnt > 65535) mon_cnt = 65535;
`endif
      if (!rst_n) begin
         chk("rst_valid", m_wr_valid, 1'b0);
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            chk("hold_valid", m_wr_valid, 1'b1);
            chk("hold_addr", m_wr_addr, st_addr);
            chk("hold_data", m_wr_data, st_data);
         end
         if (m_wr_valid && m_wr_ready) begin
            n_wr++;
            obs_addr.push_back(m_wr_addr);
            if (wq.size() == 0) begin
               chk("unexpected_write", 1'b1, 1'b0);
            end else begin
               w = wq.pop_front();
               chk("wr_addr", m_wr_addr, w[55:24]);
               chk("wr_data", m_wr_data, w[23:0]);
            end
         end
         stalled = m_wr_valid && !m_wr_ready;
         st_addr = m_wr_addr;
         st_data = m_wr_data;
      end
   end

   // Random write-side backpressure when enabled
   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) m_wr_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [23:0] d, input logic u, input logic l);
      int   waited = 0;
      logic acc;
      s_axis_tdata  = d;
      s_axis_tuser  = u;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      do begin
         @(negedge clk);
         acc = s_axis_tready;
         tick();
         waited++;
      end while (!acc && waited < 200);
      if (!acc) chk("handshake_timeout", 1'b0, 1'b1);
      s_axis_tvalid = 1'b0;
      if (gap_en && $urandom_range(0, 3) == 0) tick();
   endtask

   task automatic send_line(input int len, input bit sof);
      for (int i = 0; i < len; i++)
         send_beat(24'($urandom()), sof && (i == 0), i == len - 1);
   endtask

   task automatic drain();
      repeat (6) tick();
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      wq.delete();
      fq.delete();
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, f0, s0, l0, o0;
      rst_n = 1'b0;
      s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
      m_wr_ready = 1'b1;
      repeat (3) tick();
      chk("reset_addr", m_wr_addr, 32'h0);
      chk("reset_data", m_wr_data, 24'h0);
      chk("reset_valid", m_wr_valid, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_tready", s_axis_tready, 1'b0);
      rst_n = 1'b1;
      tick();

      // Clean 8-beat frame
      w0 = n_wr; f0 = n_fd; s0 = n_short + n_long + n_sof; obs_addr.delete();
      send_line(4, 1'b1);
      send_line(4, 1'b0);
      drain();
      chk("t1_writes", n_wr - w0, 8);
      chk("t1_frame_done", n_fd - f0, 1);
      chk("t1_errors", n_short + n_long + n_sof - s0, 0);
      chk("t1_last_addr", obs_addr[7], 32'h11C);

      // Backpressure mid-line
      w0 = n_wr; f0 = n_fd;
      fork
         begin
            send_line(4, 1'b1);
            send_line(4, 1'b0);
         end
         begin
            repeat (2) tick();
            m_wr_ready = 1'b0;
            #1;
            chk("bp_tready_low", s_axis_tready, 1'b0);
            chk("bp_valid_held", m_wr_valid, 1'b1);
            repeat (3) tick();
            m_wr_ready = 1'b1;
         end
      join
      drain();
      chk("t2_writes", n_wr - w0, 8);
      chk("t2_frame_done", n_fd - f0, 1);

      // Short line 0 (2 beats)
      w0 = n_wr; s0 = n_short; obs_addr.delete();
      send_line(2, 1'b1);
      send_line(4, 1'b0);
      drain();
      chk("t3_short", n_short - s0, 1);
      chk("t3_writes", n_wr - w0, 6);
      chk("t3_next_addr", obs_addr[2], 32'h110);

      // Long line 0 (6 beats)
      w0 = n_wr; l0 = n_long; obs_addr.delete();
      send_line(6, 1'b1);
      send_line(4, 1'b0);
      drain();
      chk("t4_long", n_long - l0, 1);
      chk("t4_writes", n_wr - w0, 8);
      chk("t4_next_addr", obs_addr[4], 32'h110);

      // SOF alignment, from a fresh reset so the error count starts at 0
      reset_pulse();
      w0 = n_wr; o0 = n_sof; obs_addr.delete();
      send_beat(24'h0000AA, 1'b0, 1'b0);
      send_beat(24'h0000BB, 1'b0, 1'b0);
      drain();
      chk("t5_no_early_writes", n_wr - w0, 0);
      send_line(4, 1'b1);
      send_beat(24'h000011, 1'b0, 1'b0);
      send_beat(24'h000022, 1'b0, 1'b0);
      send_line(4, 1'b1);
      send_line(4, 1'b0);
      drain();
      chk("t5_err_sof", n_sof - o0, 1);
      chk("t5_sof_addr", obs_addr[6], 32'h100);
      chk("t5_first_addr", obs_addr[0], 32'h100);
`ifdef AXIS_FB_WRITER_ERR_CNT_EN
      chk("t5_err_count", err_count, 16'd1);
`endif

      // Reset mid-frame at line 1, x=2 with a write pending
      send_line(4, 1'b1);
      send_beat(24'h000033, 1'b0, 1'b0);
      send_beat(24'h000044, 1'b0, 1'b0);
      m_wr_ready = 1'b0;
      rst_n = 1'b0;
      wq.delete();
      fq.delete();
      #1;
      chk("t6_valid_dropped", m_wr_valid, 1'b0);
      chk("t6_tready_low", s_axis_tready, 1'b0);
      repeat (2) tick();
      rst_n = 1'b1;
      m_wr_ready = 1'b1;
      w0 = n_wr;
      send_beat(24'h000055, 1'b0, 1'b0);
      send_beat(24'h000066, 1'b0, 1'b1);
      send_beat(24'h000077, 1'b0, 1'b0);
      drain();
      chk("t6_no_writes", n_wr - w0, 0);
      chk("t6_busy", busy, 1'b0);

      // Randomized frames with errors, gaps and backpressure
      rand_rdy = 1'b1;
      gap_en   = 1'b1;
      for (int f = 0; f < 40; f++) begin
         int junk;
         junk = $urandom_range(0, 2);
         for (int j = 0; j < junk; j++)
            send_beat(24'($urandom()), 1'b0, 1'($urandom_range(0, 1)));
         for (int l = 0; l < V; l++) begin
            int len;
            len = ($urandom_range(0, 9) < 7) ? H : $urandom_range(1, 7);
            for (int i = 0; i < len; i++)
               send_beat(24'($urandom()),
                         ((f != 0 || l != 0 || i != 0) ? 1'b0 : 1'b1) |
                         ((l == 0 && i == 0) ? 1'b1 : 1'b0) |
                         (($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0),
                         i == len - 1);
         end
      end
      rand_rdy = 1'b0;
      gap_en   = 1'b0;
      m_wr_ready = 1'b1;
      drain();
      chk("final_write_queue_empty", wq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
